// File: rtl/alu_share_ctrl.sv
// Round-robin controller that shares one registered 4-op ALU between two
// valid/ready requesters and returns tagged results on a backpressured channel.
module alu_share_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    r0_valid,
  output logic                    r0_ready,
  input  logic [1:0]              r0_opcode,
  input  logic signed [3:0]       r0_a,
  input  logic signed [3:0]       r0_b,
  input  logic                    r1_valid,
  output logic                    r1_ready,
  input  logic [1:0]              r1_opcode,
  input  logic signed [3:0]       r1_a,
  input  logic signed [3:0]       r1_b,
  output logic [1:0]              alu_opcode,
  output logic signed [3:0]       alu_a,
  output logic signed [3:0]       alu_b,
  input  logic signed [4:0]       alu_c,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic                    resp_id,
  output logic signed [4:0]       resp_data,
  output logic [CNT_W-1:0]        op_count,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t state;
  state_t state_next;
  logic   rr_ptr;
  logic   owner;
  logic   grant_vld;
  logic   grant_id;

  always_comb begin
    state_next = state;
    grant_vld  = 1'b0;
    grant_id   = 1'b0;
    case (state)
      IDLE: begin
        // Ready is combinational, so it must be held off while reset is applied.
        grant_vld = (r0_valid | r1_valid) & ~reset;
        grant_id  = (r0_valid & r1_valid) ? rr_ptr : r1_valid;
        if (grant_vld) state_next = ISSUE;
      end
      ISSUE:   state_next = CAPTURE;
      CAPTURE: state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign r0_ready = grant_vld & ~grant_id;
  assign r1_ready = grant_vld & grant_id;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr     <= 1'b0;
      owner      <= 1'b0;
      alu_opcode <= 2'b00;
      alu_a      <= 4'sd0;
      alu_b      <= 4'sd0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_data  <= 5'sd0;
      op_count   <= '0;
    end else begin
      // Accept: latch the winner's operands; they stay put until the next grant.
      if (grant_vld) begin
        alu_opcode <= grant_id ? r1_opcode : r0_opcode;
        alu_a      <= grant_id ? r1_a : r0_a;
        alu_b      <= grant_id ? r1_b : r0_b;
        owner      <= grant_id;
      end
      // Capture: the ALU result registered at the end of ISSUE is now on alu_c.
      if (state == CAPTURE) begin
        resp_data  <= alu_c;
        resp_id    <= owner;
        resp_valid <= 1'b1;
      end
      // Response handshake: hand priority to the requester that was not just served.
      if (state == RESP && resp_ready) begin
        resp_valid <= 1'b0;
        op_count   <= op_count + CNT_W'(1);
        rr_ptr     <= ~resp_id;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Randomized and directed bench for alu_share_ctrl with a transaction-level
// reference model and a behavioural stand-in for the shared ALU.
module tb_alu_share_ctrl;

  localparam int CNT_W = 3;
  localparam int CNT_MOD = 1 << CNT_W;

  typedef struct packed {
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
  } op_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             r0_valid, r0_ready, r1_valid, r1_ready;
  logic [1:0]       r0_opcode, r1_opcode, alu_opcode;
  logic [3:0]       r0_a, r0_b, r1_a, r1_b, alu_a, alu_b;
  logic [4:0]       alu_c, resp_data;
  logic             resp_valid, resp_ready, resp_id, busy;
  logic [CNT_W-1:0] op_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_opcode(r0_opcode), .r0_a(r0_a), .r0_b(r0_b),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_opcode(r1_opcode), .r1_a(r1_a), .r1_b(r1_b),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_data(resp_data),
    .op_count(op_count), .busy(busy)
  );

  // Shared ALU: 1-cycle registered result from whatever operands are presented.
  always_ff @(posedge clk) begin
    case (alu_opcode)
      2'b00:   alu_c <= {alu_a[3], alu_a} + {alu_b[3], alu_b};
      2'b01:   alu_c <= {alu_a[3], alu_a} - {alu_b[3], alu_b};
      2'b10:   alu_c <= ~{alu_a[3], alu_a};
      default: alu_c <= {4'b0000, |alu_b};
    endcase
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] ref_result(input op_t o);
    int sa;
    int sb;
    int r;
    sa = $signed(o.a);
    sb = $signed(o.b);
    case (o.op)
      2'd0:    r = sa + sb;
      2'd1:    r = sa - sb;
      2'd2:    r = -sa - 1;
      default: r = (sb != 0) ? 1 : 0;
    endcase
    return r[4:0];
  endfunction

  function automatic op_t mk(input int op, input int a, input int b);
    op_t o;
    o.op = op[1:0];
    o.a  = a[3:0];
    o.b  = b[3:0];
    return o;
  endfunction

  // Reference model: one outstanding transaction, counted in cycles since accept.
  logic       m_live = 1'b0;
  logic       m_pend, m_id, m_pref, m_rid;
  int         m_lat, m_count;
  logic [4:0] m_data, m_rdata;
  op_t        m_alu;
  logic       exp_g, exp_id;
  op_t        exp_op;
  logic [5:0] hist[$];

  always @(negedge clk) begin
    exp_g  = (r0_valid | r1_valid) & ~reset;
    exp_id = (r0_valid && r1_valid) ? m_pref : r1_valid;
    exp_op = exp_id ? op_t'({r1_opcode, r1_a, r1_b}) : op_t'({r0_opcode, r0_a, r0_b});
    if (m_live) begin
      check_val("r0_ready", r0_ready, !m_pend && exp_g && !exp_id);
      check_val("r1_ready", r1_ready, !m_pend && exp_g && exp_id);
      check_val("busy", busy, m_pend);
      check_val("resp_valid", resp_valid, m_pend && m_lat >= 3);
      check_val("resp_id", resp_id, m_rid);
      check_val("resp_data", resp_data, m_rdata);
      check_val("op_count", op_count, m_count % CNT_MOD);
      check_val("alu_operands", {alu_opcode, alu_a, alu_b}, m_alu);
      if (resp_valid && resp_ready) hist.push_back({resp_id, resp_data});
    end
    if (reset) begin
      m_live = 1'b1; m_pend = 1'b0; m_lat = 0; m_pref = 1'b0; m_count = 0;
      m_rid = 1'b0; m_rdata = 5'd0; m_alu = '0; m_id = 1'b0; m_data = 5'd0;
    end else if (m_live) begin
      if (!m_pend) begin
        if (exp_g) begin
          m_alu = exp_op; m_id = exp_id; m_data = ref_result(exp_op);
          m_pend = 1'b1; m_lat = 1;
        end
      end else if (m_lat >= 3) begin
        if (resp_ready) begin
          m_count++; m_pref = ~m_id; m_pend = 1'b0;
        end
      end else begin
        m_lat++;
        if (m_lat == 3) begin m_rdata = m_data; m_rid = m_id; end
      end
    end
  end

  // Requester drivers: hold each op until accepted, then take the next one.
  op_t q0[$];
  op_t q1[$];
  logic h0, h1;
  int rnd_on = 0;
  int p_req = 60;
  int rdy_pct = 100;

  function automatic op_t rand_op();
    return mk($urandom_range(3), $urandom_range(15), $urandom_range(15));
  endfunction

  task automatic step();
    op_t o;
    @(negedge clk);
    h0 = r0_valid & r0_ready;
    h1 = r1_valid & r1_ready;
    @(posedge clk);
    #1;
    if (h0) r0_valid = 1'b0;
    if (h1) r1_valid = 1'b0;
    if (!r0_valid && (q0.size() > 0 || (rnd_on != 0 && $urandom_range(99) < p_req))) begin
      o = (q0.size() > 0) ? q0.pop_front() : rand_op();
      {r0_opcode, r0_a, r0_b} = o;
      r0_valid = 1'b1;
    end
    if (!r1_valid && (q1.size() > 0 || (rnd_on != 0 && $urandom_range(99) < p_req))) begin
      o = (q1.size() > 0) ? q1.pop_front() : rand_op();
      {r1_opcode, r1_a, r1_b} = o;
      r1_valid = 1'b1;
    end
    resp_ready = ($urandom_range(99) < rdy_pct);
  endtask

  task automatic wait_quiet(input int lim);
    int n;
    n = 0;
    while (!(!m_pend && q0.size() == 0 && q1.size() == 0 && !r0_valid && !r1_valid) && n < lim) begin
      step();
      n++;
    end
    check_val("quiet_within_bound", n < lim, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int n;
    int hs;
    reset = 1'b1; resp_ready = 1'b1;
    r0_valid = 1'b0; r0_opcode = 2'b00; r0_a = 4'd0; r0_b = 4'd0;
    r1_valid = 1'b0; r1_opcode = 2'b00; r1_a = 4'd0; r1_b = 4'd0;
    do_reset();
    check_val("reset_busy", busy, 0);
    check_val("reset_resp_valid", resp_valid, 0);
    check_val("reset_op_count", op_count, 0);

    q0.push_back(mk(0, 3, 4));
    wait_quiet(20);
    check_val("add_r0", hist[$], {1'b0, 5'b00111});
    check_val("add_count", op_count, 1);

    q1.push_back(mk(1, 2, 5));
    q1.push_back(mk(2, 5, 0));
    wait_quiet(30);
    check_val("sub_r1", hist[$-1], {1'b1, 5'b11101});
    check_val("not_r1", hist[$], {1'b1, 5'b11010});

    do_reset();
    for (int i = 0; i < 2; i++) begin
      q0.push_back(mk(3, 0, 0));
      q1.push_back(mk(3, 0, -8));
    end
    wait_quiet(40);
    check_val("rr_g0", hist[$-3], {1'b0, 5'd0});
    check_val("rr_g1", hist[$-2], {1'b1, 5'd1});
    check_val("rr_g2", hist[$-1], {1'b0, 5'd0});
    check_val("rr_g3", hist[$], {1'b1, 5'd1});
    check_val("rr_count", op_count, 4);

    rdy_pct = 0;
    q0.push_back(mk(0, 1, 1));
    step();
    q1.push_back(mk(2, -8, 0));
    for (int i = 0; i < 12; i++) step();
    check_val("hold_resp_valid", resp_valid, 1);
    check_val("hold_r1_ready", r1_ready, 0);
    check_val("hold_data", {resp_id, resp_data}, {1'b0, 5'b00010});
    rdy_pct = 100;
    n = 0;
    do begin step(); n++; end while (!h1 && n < 10);
    check_val("r1_granted_after_release", h1, 1);
    wait_quiet(20);
    check_val("hold_r1_result", hist[$], {1'b1, 5'b00111});
    check_val("hold_count", op_count, 6);

    hs = hist.size();
    q0.push_back(mk(0, 7, 7));
    n = 0;
    do begin step(); n++; end while (!h0 && n < 10);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_val("midop_reset_resp_valid", resp_valid, 0);
    check_val("midop_reset_busy", busy, 0);
    check_val("midop_reset_count", op_count, 0);
    for (int i = 0; i < 8; i++) step();
    check_val("midop_no_response", hist.size(), hs);

    for (int i = 0; i < CNT_MOD - 1; i++) q0.push_back(rand_op());
    wait_quiet(200);
    check_val("count_max", op_count, CNT_MOD - 1);
    q1.push_back(rand_op());
    wait_quiet(20);
    check_val("count_wrap", op_count, 0);

    rnd_on = 1; rdy_pct = 70;
    for (int i = 0; i < 600; i++) step();
    rnd_on = 0;
    rdy_pct = 100;
    wait_quiet(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
